// File: rtl/motion_delta_encoder_pkg.sv
// Shared definitions for the motion-vector delta encoder: FSM state codes,
// default widths and the f_code field selector.
package motion_delta_encoder_pkg;

    localparam int MAG_WIDTH_DEF  = 13;
    localparam int F_CODE_MAX_DEF = 9;
    localparam int SIGN_BIT       = MAG_WIDTH_DEF;
    localparam int WORD_W         = 16;
    localparam int CNT_W          = 4;
    localparam int IDX_W          = 3;

    typedef enum logic {
        MB_PREDICT_ENCODE_IDLE = 1'b0,
        MB_PREDICT_ENCODE_CALC = 1'b1
    } enc_state_e;

    // Pick one 4-bit f_code out of {f[0][0], f[0][1], f[1][0], f[1][1]}.
    function automatic logic [3:0] f_code_sel(input logic [WORD_W-1:0] f_codes,
                                              input logic [1:0]        sel);
        case (sel)
            2'd0:    return f_codes[15:12];
            2'd1:    return f_codes[11:8];
            2'd2:    return f_codes[7:4];
            default: return f_codes[3:0];
        endcase
    endfunction

endpackage

// File: rtl/motion_delta_encoder_if.sv
// Bus between the delta encoder (master) and its controller plus the
// target/PMV/delta stores (slave).
interface motion_delta_encoder_if;
    import motion_delta_encoder_pkg::*;

    logic              Start_Encode_I;
    logic              Done_Encode_O;
    logic [WORD_W-1:0] F_Codes_I;
    logic              PMV_Reset_I;
    logic [IDX_W-1:0]  Index_O;
    logic [WORD_W-1:0] Target_Data_I;
    logic [WORD_W-1:0] PMV_Data_I;
    logic [WORD_W-1:0] Delta_Data_O;
    logic              Delta_Write_En_O;
    logic [WORD_W-1:0] PMV_Data_O;
    logic              PMV_Write_En_O;
    logic              Range_Error_O;

    modport master (
        input  Start_Encode_I, F_Codes_I, PMV_Reset_I, Target_Data_I, PMV_Data_I,
        output Done_Encode_O, Index_O, Delta_Data_O, Delta_Write_En_O,
               PMV_Data_O, PMV_Write_En_O, Range_Error_O
    );

    modport slave (
        output Start_Encode_I, F_Codes_I, PMV_Reset_I, Target_Data_I, PMV_Data_I,
        input  Done_Encode_O, Index_O, Delta_Data_O, Delta_Write_En_O,
               PMV_Data_O, PMV_Write_En_O, Range_Error_O
    );

endinterface

// File: rtl/motion_delta_encoder_delta_former.sv
// delta_former: combinational target/PMV -> sign-magnitude delta word, the
// inverse of the decoder's new-prediction former. With MV_ENC_RANGE_CHECK_EN
// defined it also reports an out-of-range target or an illegal f_code.
module delta_former
    import motion_delta_encoder_pkg::*;
#(
    parameter int MAG_WIDTH  = MAG_WIDTH_DEF
`ifdef MV_ENC_RANGE_CHECK_EN
   ,parameter int F_CODE_MAX = F_CODE_MAX_DEF
`endif
) (
    input  logic signed [WORD_W-1:0] target_i,
    input  logic signed [WORD_W-1:0] pmv_i,
    input  logic        [3:0]        f_code_i,
    output logic        [WORD_W-1:0] delta_o
`ifdef MV_ENC_RANGE_CHECK_EN
   ,output logic                     range_err_o
`endif
);

    // Wide enough for 32 << 14 (f_code 15) without overflow.
    localparam int AW = 22;

    logic        [3:0]    fc_eff;
    logic        [3:0]    rs;
    logic signed [16:0]   d17;
    logic signed [AW-1:0] half;
    logic signed [AW-1:0] range_w;
    logic signed [AW-1:0] low;
    logic signed [AW-1:0] high;
    logic signed [AW-1:0] d_w;
    logic signed [AW-1:0] d_wrap;
    logic signed [AW-1:0] mag_w;
    logic                 neg;

    // Difference, single fold into [low, high], then sign-magnitude packing.
    always_comb begin
        fc_eff  = (f_code_i == 4'd0) ? 4'd1 : f_code_i;
        rs      = fc_eff - 4'd1;
        half    = AW'(16) << rs;
        range_w = half <<< 1;
        low     = -half;
        high    = half - AW'(1);
        d17     = {target_i[WORD_W-1], target_i} - {pmv_i[WORD_W-1], pmv_i};
        d_w     = {{(AW-17){d17[16]}}, d17};
        if (d_w < low)
            d_wrap = d_w + range_w;
        else if (d_w > high)
            d_wrap = d_w - range_w;
        else
            d_wrap = d_w;
        neg   = d_wrap[AW-1];
        mag_w = neg ? -d_wrap : d_wrap;
        delta_o                = '0;
        delta_o[MAG_WIDTH]     = neg;
        delta_o[MAG_WIDTH-1:0] = mag_w[MAG_WIDTH-1:0];
    end

`ifdef MV_ENC_RANGE_CHECK_EN
    logic signed [AW-1:0] tgt_w;

    // Target must already lie inside the f_code window.
    always_comb begin
        tgt_w       = {{(AW-WORD_W){target_i[WORD_W-1]}}, target_i};
        range_err_o = (tgt_w < low) || (tgt_w > high) || (f_code_i > 4'(F_CODE_MAX));
    end
`endif

endmodule

// File: rtl/motion_delta_encoder.sv
// motion_delta_encoder: walks the 8 MV entries of a macroblock, writing a
// delta word and the new PMV for each. Optional range checking is built when
// MV_ENC_RANGE_CHECK_EN is defined; otherwise Range_Error_O is tied low.
module motion_delta_encoder
    import motion_delta_encoder_pkg::*;
#(
    parameter int MAG_WIDTH  = MAG_WIDTH_DEF,
    parameter int F_CODE_MAX = F_CODE_MAX_DEF
) (
    input  logic                   clock,
    input  logic                   resetn,
    motion_delta_encoder_if.master bus
);

    enc_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [WORD_W-1:0] delta_q;
    logic [WORD_W-1:0] pmv_q;
    logic              we_q;
    logic [3:0]        f_code_d;
    logic [WORD_W-1:0] pmv_rd_d;
    logic [WORD_W-1:0] delta_d;

    assign bus.Index_O          = cnt_q[3:1];
    assign bus.Done_Encode_O    = (state_q == MB_PREDICT_ENCODE_IDLE);
    assign bus.Delta_Data_O     = delta_q;
    assign bus.PMV_Data_O       = pmv_q;
    assign bus.Delta_Write_En_O = we_q;
    assign bus.PMV_Write_En_O   = we_q;

    // Select the f_code for the current entry and apply the PMV reset override.
    always_comb begin
        f_code_d = f_code_sel(bus.F_Codes_I, {cnt_q[3], cnt_q[1]});
        pmv_rd_d = bus.PMV_Reset_I ? '0 : bus.PMV_Data_I;
    end

`ifdef MV_ENC_RANGE_CHECK_EN
    logic rerr_d;
    logic rerr_q;

    delta_former #(.MAG_WIDTH(MAG_WIDTH), .F_CODE_MAX(F_CODE_MAX)) u_former (
        .target_i    (bus.Target_Data_I),
        .pmv_i       (pmv_rd_d),
        .f_code_i    (f_code_d),
        .delta_o     (delta_d),
        .range_err_o (rerr_d)
    );

    // Sticky range flag: cleared when a walk starts, set as an entry is written.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            rerr_q <= 1'b0;
        else if (state_q == MB_PREDICT_ENCODE_IDLE && bus.Start_Encode_I)
            rerr_q <= 1'b0;
        else if (state_q == MB_PREDICT_ENCODE_CALC && !cnt_q[0] && rerr_d)
            rerr_q <= 1'b1;
    end

    assign bus.Range_Error_O = rerr_q;
`else
    delta_former #(.MAG_WIDTH(MAG_WIDTH)) u_former (
        .target_i (bus.Target_Data_I),
        .pmv_i    (pmv_rd_d),
        .f_code_i (f_code_d),
        .delta_o  (delta_d)
    );

    assign bus.Range_Error_O = 1'b0;
`endif

    // Walk FSM: even cycles capture an entry, the following odd cycle writes it.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= MB_PREDICT_ENCODE_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            delta_q <= '0;
            pmv_q   <= '0;
        end else begin
            case (state_q)
                MB_PREDICT_ENCODE_IDLE: begin
                    we_q <= 1'b0;
                    if (bus.Start_Encode_I) begin
                        state_q <= MB_PREDICT_ENCODE_CALC;
                        cnt_q   <= '0;
                    end
                end
                MB_PREDICT_ENCODE_CALC: begin
                    cnt_q <= cnt_q + 4'd1;
                    we_q  <= ~cnt_q[0];
                    if (!cnt_q[0]) begin
                        delta_q <= delta_d;
                        pmv_q   <= bus.Target_Data_I;
                    end
                    if (cnt_q == 4'hF)
                        state_q <= MB_PREDICT_ENCODE_IDLE;
                end
                default: state_q <= MB_PREDICT_ENCODE_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_motion_delta_encoder.sv
// Directed bench for motion_delta_encoder with behavioural target/PMV/delta
// stores. Range-flag expectations follow MV_ENC_RANGE_CHECK_EN.
module tb_motion_delta_encoder;
    import motion_delta_encoder_pkg::*;

`ifdef MV_ENC_RANGE_CHECK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    logic clr    = 1'b0;

    always #5 clock = ~clock;

    motion_delta_encoder_if bus();

    motion_delta_encoder dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    logic [15:0] tgt_mem   [8];
    logic [15:0] pmv_init  [8];
    logic [15:0] pmv_mem   [8];
    logic [15:0] delta_mem [8];
    logic [2:0]  wr_idx    [16];
    int          pwr_cnt;
    int          dwr_cnt;
    int          n_vec = 0;
    int          n_bad = 0;

    assign bus.Target_Data_I = tgt_mem[bus.Index_O];
    assign bus.PMV_Data_I    = pmv_mem[bus.Index_O];

    always @(posedge clock) begin
        if (clr) begin
            pmv_mem <= pmv_init;
            for (int i = 0; i < 8; i++) delta_mem[i] <= 16'h0000;
            pwr_cnt <= 0;
            dwr_cnt <= 0;
        end else begin
            if (bus.PMV_Write_En_O) begin
                pmv_mem[bus.Index_O] <= bus.PMV_Data_O;
                if (pwr_cnt < 16) wr_idx[pwr_cnt] <= bus.Index_O;
                pwr_cnt <= pwr_cnt + 1;
            end
            if (bus.Delta_Write_En_O) begin
                delta_mem[bus.Index_O] <= bus.Delta_Data_O;
                dwr_cnt <= dwr_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_stores();
        clr = 1'b1;
        @(posedge clock);
        #1 clr = 1'b0;
    endtask

    task automatic walk(input bit mid_start, output int cycles);
        @(negedge clock);
        bus.Start_Encode_I = 1'b1;
        @(posedge clock);
        #1 bus.Start_Encode_I = 1'b0;
        cycles = 0;
        while (cycles < 40) begin
            @(posedge clock);
            cycles++;
            #1;
            bus.Start_Encode_I = mid_start && (cycles == 4 || cycles == 5);
            if (bus.Done_Encode_O) break;
        end
        bus.Start_Encode_I = 1'b0;
    endtask

    initial begin
        logic [15:0] exp_d [8];
        int          cyc;

        bus.Start_Encode_I = 1'b0;
        bus.PMV_Reset_I    = 1'b0;
        bus.F_Codes_I      = 16'h1111;
        for (int i = 0; i < 8; i++) begin
            tgt_mem[i]  = 16'h0000;
            pmv_init[i] = 16'h0000;
        end
        clr = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_done",  16'(bus.Done_Encode_O),    16'h0001);
        check("rst_pwe",   16'(bus.PMV_Write_En_O),   16'h0000);
        check("rst_dwe",   16'(bus.Delta_Write_En_O), 16'h0000);
        check("rst_delta", bus.Delta_Data_O,          16'h0000);
        check("rst_pmv",   bus.PMV_Data_O,            16'h0000);
        check("rst_index", 16'(bus.Index_O),          16'h0000);
        check("rst_rerr",  16'(bus.Range_Error_O),    16'h0000);
        clr = 1'b0;
        @(negedge clock);
        resetn = 1'b1;

        // f_code 1 everywhere: plain delta, both wrap directions, d == low, d == 0
        tgt_mem  = '{16'h0005, 16'hFFF0, 16'h000F, 16'h0000, 16'hFFF0, 16'h000F, 16'hFFFD, 16'h0007};
        pmv_init = '{16'h0003, 16'h000F, 16'hFFF0, 16'h0000, 16'h0000, 16'h0000, 16'h0002, 16'hFFF7};
        exp_d    = '{16'h0002, 16'h0001, 16'h2001, 16'h0000, 16'h2010, 16'h000F, 16'h2005, 16'h2010};
        load_stores();
        walk(1'b0, cyc);
        check("t1_cycles", 16'(cyc), 16'd16);
        check("t1_pwr", 16'(pwr_cnt), 16'd8);
        check("t1_dwr", 16'(dwr_cnt), 16'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t1_delta%0d", i), delta_mem[i], exp_d[i]);
            check($sformatf("t1_pmv%0d", i),   pmv_mem[i],   tgt_mem[i]);
            check($sformatf("t1_idx%0d", i),   16'(wr_idx[i]), 16'(i));
        end
        check("t1_rerr", 16'(bus.Range_Error_O), 16'h0000);

        // Mixed f_codes exercise every nibble of F_Codes_I
        bus.F_Codes_I = 16'h2131;
        tgt_mem  = '{16'h0014, 16'h0014, 16'hFFE0, 16'h0000, 16'h0064, 16'h0001, 16'hFFC0, 16'h0000};
        pmv_init = '{16'hFFEC, 16'hFFEC, 16'h0000, 16'h0000, 16'hFFE2, 16'h0001, 16'h0000, 16'h0000};
        exp_d    = '{16'h2018, 16'h0008, 16'h2020, 16'h0000, 16'h0002, 16'h0000, 16'h2040, 16'h0000};
        load_stores();
        walk(1'b0, cyc);
        check("t2_cycles", 16'(cyc), 16'd16);
        for (int i = 0; i < 8; i++)
            check($sformatf("t2_delta%0d", i), delta_mem[i], exp_d[i]);
        check("t2_rerr", 16'(bus.Range_Error_O), 16'(RC));

        // PMV reset, f_code 0 read as 1, Start re-pulsed mid-walk
        bus.F_Codes_I   = 16'h0000;
        bus.PMV_Reset_I = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tgt_mem[i]  = 16'hFFF9;
            pmv_init[i] = 16'h0064;
        end
        load_stores();
        walk(1'b1, cyc);
        check("t3_cycles", 16'(cyc), 16'd16);
        check("t3_pwr", 16'(pwr_cnt), 16'd8);
        check("t3_dwr", 16'(dwr_cnt), 16'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t3_delta%0d", i), delta_mem[i], 16'h2007);
            check($sformatf("t3_pmv%0d", i),   pmv_mem[i],   16'hFFF9);
        end
        check("t3_rerr_cleared", 16'(bus.Range_Error_O), 16'h0000);
        repeat (3) @(posedge clock);
        #1 check("t3_idle_pwr", 16'(pwr_cnt), 16'd8);
        bus.PMV_Reset_I = 1'b0;

        // f_code above the legal maximum
        bus.F_Codes_I = 16'hA111;
        for (int i = 0; i < 8; i++) begin
            tgt_mem[i]  = 16'h0000;
            pmv_init[i] = 16'h0000;
        end
        load_stores();
        walk(1'b0, cyc);
        check("t5_delta0", delta_mem[0], 16'h0000);
        check("t5_rerr", 16'(bus.Range_Error_O), 16'(RC));

        // Target just outside the f_code 1 window; flag holds after the walk
        bus.F_Codes_I = 16'h1111;
        tgt_mem[0] = 16'h0010;
        load_stores();
        walk(1'b0, cyc);
        check("t4_delta0", delta_mem[0], 16'h2010);
        check("t4_pmv0", pmv_mem[0], 16'h0010);
        check("t4_rerr", 16'(bus.Range_Error_O), 16'(RC));
        repeat (3) @(posedge clock);
        #1 check("t4_rerr_held", 16'(bus.Range_Error_O), 16'(RC));

        // Asynchronous reset while counter == 5
        tgt_mem = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008};
        load_stores();
        @(negedge clock);
        bus.Start_Encode_I = 1'b1;
        @(posedge clock);
        #1 bus.Start_Encode_I = 1'b0;
        repeat (5) @(posedge clock);
        #1 resetn = 1'b0;
        #1;
        check("mr_done",  16'(bus.Done_Encode_O),    16'h0001);
        check("mr_pwe",   16'(bus.PMV_Write_En_O),   16'h0000);
        check("mr_dwe",   16'(bus.Delta_Write_En_O), 16'h0000);
        check("mr_delta", bus.Delta_Data_O,          16'h0000);
        check("mr_pmv",   bus.PMV_Data_O,            16'h0000);
        check("mr_rerr",  16'(bus.Range_Error_O),    16'h0000);
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check("mr_pwr", 16'(pwr_cnt), 16'd2);
        check("mr_dwr", 16'(dwr_cnt), 16'd2);
        check("mr_delta0", delta_mem[0], 16'h0001);
        check("mr_delta1", delta_mem[1], 16'h0002);
        for (int i = 3; i < 8; i++)
            check($sformatf("mr_pmv%0d", i), pmv_mem[i], 16'h0000);
        check("mr_idle", 16'(bus.Done_Encode_O), 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
